// File: rtl/spiker_fifo_pkg.sv
// spiker_fifo_pkg
// Shared types for the spike-result frame FIFO:
//   policy_e      - full-FIFO policy (stall/drop or overwrite-oldest)
//   fsm_state_e   - result-window control state (IDLE, HOLD)
//   n_reg_ceil()  - minimum result words needed to hold a DATA_WIDTH frame
// The frame entry struct depends on module parameters, so it is declared
// inside spiker_result_fifo. Its layout is {seq, [popcount,] data}.
package spiker_fifo_pkg;

  typedef enum logic {
    POLICY_STALL     = 1'b0,
    POLICY_OVERWRITE = 1'b1
  } policy_e;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_HOLD = 1'b1
  } fsm_state_e;

  function automatic int n_reg_ceil(input int data_width, input int width);
    return (data_width + width - 1) / width;
  endfunction

endpackage

// File: rtl/spiker_frame_ram.sv
// spiker_frame_ram
// DEPTH x ENTRY_W frame storage with a synchronous write port and a
// registered read port. The read register only loads on re_i, so it holds
// the last popped entry between pops. A same-address read and write in one
// cycle returns the old contents.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i       read enable/address
//   rdata_o            registered read data
module spiker_frame_ram #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 8,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] rdata_q;

  // The contents need no reset: the pointers and level are reset, so stale
  // entries are never read back.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spiker_result_fifo.sv
// spiker_result_fifo
// Frame FIFO between the spiking-core output and the adapter register file.
// Frames are pushed with ready_i, and software pops one at a time with
// sample_i. The popped head appears on spikes_result_o one clock later.
// Optional feature: define SPIKER_RESULT_FIFO_POPCOUNT_EN to add popcount_o.
// This is the set-bit count of the presented frame, computed at push time.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   data_out_i        core result vector (DATA_WIDTH)
//   ready_i           push strobe
//   sample_i          pop request pulse
//   clear_i           clear sticky flags and the sequence counter
//   writer_ready_o    a push can be accepted
//   spikes_result_o   presented frame, N_REG words of WIDTH, zero-padded
//   result_valid_o    spikes_result_o holds a popped frame
//   frame_seq_o       sequence number of the presented frame
//   level_o           stored frame count
//   overflow_o        sticky: a push was dropped or overwrote data
//   underflow_o       sticky: pop while empty
//   dbg_state_o       control FSM state (IDLE/HOLD)
//   popcount_o        (macro only) set bits in the presented frame
module spiker_result_fifo
  import spiker_fifo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DATA_WIDTH = 800,
  parameter int N_REG      = 25,
  parameter int DEPTH      = 4,
  parameter int OVERWRITE  = 0,
  parameter int SEQ_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH-1:0]     data_out_i,
  input  logic                      ready_i,
  input  logic                      sample_i,
  input  logic                      clear_i,
  output logic                      writer_ready_o,
  output logic [N_REG*WIDTH-1:0]    spikes_result_o,
  output logic                      result_valid_o,
  output logic [SEQ_W-1:0]          frame_seq_o,
  output logic [$clog2(DEPTH):0]    level_o,
`ifdef SPIKER_RESULT_FIFO_POPCOUNT_EN
  output logic [$clog2(DATA_WIDTH+1)-1:0] popcount_o,
`endif
  output logic                      overflow_o,
  output logic                      underflow_o,
  output fsm_state_e                dbg_state_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int PC_W  = $clog2(DATA_WIDTH + 1);
  localparam policy_e POLICY = (OVERWRITE != 0) ? POLICY_OVERWRITE : POLICY_STALL;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  if (N_REG < n_reg_ceil(DATA_WIDTH, WIDTH)) begin : g_bad_n_reg
    $error("N_REG*WIDTH must cover DATA_WIDTH");
  end

  typedef struct packed {
    logic [SEQ_W-1:0]      seq;
`ifdef SPIKER_RESULT_FIFO_POPCOUNT_EN
    logic [PC_W-1:0]       popcount;
`endif
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_rdy_q;
  logic             valid_q;
  fsm_state_e       state_q;

  logic   full, empty, pop_ok, pop_empty, push_ok, ovw, drop;
  entry_t wr_entry, rd_entry;

`ifdef SPIKER_RESULT_FIFO_POPCOUNT_EN
  function automatic logic [PC_W-1:0] popcnt(input logic [DATA_WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction
`endif

  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  assign pop_ok    = sample_i && !empty;
  assign pop_empty = sample_i && empty;
  // When the FIFO is full, a concurrent pop frees the slot, so the push goes
  // in without overflow under either policy.
  assign push_ok   = ready_i && (!full || pop_ok || (POLICY == POLICY_OVERWRITE));
  assign ovw       = ready_i && full && !pop_ok && (POLICY == POLICY_OVERWRITE);
  assign drop      = ready_i && full && !pop_ok && (POLICY == POLICY_STALL);

  always_comb begin
    wr_entry      = '0;
    wr_entry.seq  = seq_q;
    wr_entry.data = data_out_i;
`ifdef SPIKER_RESULT_FIFO_POPCOUNT_EN
    wr_entry.popcount = popcnt(data_out_i);
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    seq_d    = seq_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      seq_d    = seq_q + SEQ_W'(1);
    end
    // An overwrite discards the oldest entry, so the head moves with the tail.
    if (pop_ok || ovw) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !ovw && !pop_ok)      level_d = level_q + LVL_W'(1);
    else if (pop_ok && !push_ok)         level_d = level_q - LVL_W'(1);
    if (clear_i) seq_d = '0;
    // A coincident clear takes priority over a new flag event.
    ovf_d = clear_i ? 1'b0 : (ovf_q || ovw || drop);
    udf_d = clear_i ? 1'b0 : (udf_q || pop_empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      wr_rdy_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      wr_rdy_q <= (POLICY == POLICY_OVERWRITE) ? 1'b1 : (level_d < FULL_LVL);
    end
  end

  // Result-window control: HOLD while the window holds a popped frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FSM_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        FSM_IDLE: if (pop_ok) begin
          state_q <= FSM_HOLD;
          valid_q <= 1'b1;
        end
        FSM_HOLD: if (pop_empty) begin
          state_q <= FSM_IDLE;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= FSM_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  spiker_frame_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .AW      (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .re_i    (pop_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Word i is bits [(i+1)*WIDTH-1 -: WIDTH]. The padding above DATA_WIDTH is 0.
  always_comb begin
    spikes_result_o                   = '0;
    spikes_result_o[DATA_WIDTH-1:0]   = rd_entry.data;
  end

  assign frame_seq_o    = rd_entry.seq;
  assign result_valid_o = valid_q;
  assign writer_ready_o = wr_rdy_q;
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
  assign dbg_state_o    = state_q;
`ifdef SPIKER_RESULT_FIFO_POPCOUNT_EN
  assign popcount_o     = rd_entry.popcount;
`endif

endmodule
